// File: rtl/riscv_run_pkg.sv
// Shared types and helpers for the RISC-V run monitor.
package riscv_run_pkg;

  // Run-control FSM encoding, kept as plain constants for legacy tools.
  typedef logic [1:0] run_state_e;
  localparam run_state_e StIdle    = 2'd0;
  localparam run_state_e StRstHold = 2'd1;
  localparam run_state_e StRun     = 2'd2;
  localparam run_state_e StDone    = 2'd3;

  localparam int unsigned DefResetCycles = 2;
  localparam int unsigned DefMaxCycles   = 50;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic int unsigned lowest_set_idx(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/riscv_run_monitor_prio_enc.sv
// Lowest-index priority encoder with a valid flag.
module run_prio_enc
  import riscv_run_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned IdxW  = 1
) (
  input  logic [Width-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  logic [31:0] req_ext;

  // Zero-extend the request so the shared helper can scan a fixed width.
  always_comb begin
    req_ext             = '0;
    req_ext[Width-1:0]  = req_i;
    idx_o               = IdxW'(lowest_set_idx(req_ext));
    valid_o             = |req_i;
  end

endmodule

// File: rtl/riscv_run_monitor.sv
// Run-control and end-of-test monitor for NUM_HARTS RISC-V cores.
// Optional per-hart trap timestamps: define RUN_MON_TRAP_STAMP_EN.
module riscv_run_monitor
  import riscv_run_pkg::*;
#(
  parameter int unsigned NUM_HARTS    = 1,
  parameter int unsigned RESET_CYCLES = DefResetCycles,
  parameter int unsigned MAX_CYCLES   = DefMaxCycles,
  parameter int unsigned WAIT_ALL     = 0,
  parameter int unsigned CNT_W        = $clog2(MAX_CYCLES + 1),
  parameter int unsigned ID_W         = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_HARTS-1:0]       trap,
  output logic                       core_reset,
  output logic                       running,
  output logic                       done,
  output logic                       timed_out,
  output logic [NUM_HARTS-1:0]       trap_seen,
  output logic [ID_W-1:0]            first_trap_id,
`ifdef RUN_MON_TRAP_STAMP_EN
  output logic [NUM_HARTS*CNT_W-1:0] trap_stamp,
`endif
  output logic [CNT_W-1:0]           cycle_cnt
);

  localparam int unsigned RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e           state_q, state_d;
  logic [RstW-1:0]      rst_cnt_q, rst_cnt_d;
  logic                 core_reset_q, core_reset_d;
  logic                 running_q, running_d;
  logic                 done_q, done_d;
  logic                 timed_out_q, timed_out_d;
  logic [NUM_HARTS-1:0] trap_seen_q, trap_seen_d;
  logic [ID_W-1:0]      first_trap_id_q, first_trap_id_d;
  logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;
`ifdef RUN_MON_TRAP_STAMP_EN
  logic [NUM_HARTS*CNT_W-1:0] stamp_q, stamp_d;
`endif

  logic [ID_W-1:0] prio_idx;
  logic            prio_valid;
  logic            terminate;

  run_prio_enc #(
    .Width (NUM_HARTS),
    .IdxW  (ID_W)
  ) u_prio_enc (
    .req_i   (trap),
    .idx_o   (prio_idx),
    .valid_o (prio_valid)
  );

  // Next-state logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d         = state_q;
    rst_cnt_d       = rst_cnt_q;
    done_d          = done_q;
    timed_out_d     = timed_out_q;
    trap_seen_d     = trap_seen_q;
    first_trap_id_d = first_trap_id_q;
    cycle_cnt_d     = cycle_cnt_q;
`ifdef RUN_MON_TRAP_STAMP_EN
    stamp_d         = stamp_q;
`endif
    terminate = (WAIT_ALL != 0) ? &(trap_seen_q | trap) : |trap;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d         = StRstHold;
          rst_cnt_d       = '0;
          done_d          = 1'b0;
          timed_out_d     = 1'b0;
          trap_seen_d     = '0;
          first_trap_id_d = '0;
          cycle_cnt_d     = '0;
`ifdef RUN_MON_TRAP_STAMP_EN
          stamp_d         = '0;
`endif
        end
      end
      StRstHold: begin
        if (rst_cnt_q == RstW'(RESET_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      StRun: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        trap_seen_d = trap_seen_q | trap;
        // An empty trap_seen means this is the first trap cycle of the run.
        if (prio_valid && (trap_seen_q == '0)) begin
          first_trap_id_d = prio_idx;
        end
`ifdef RUN_MON_TRAP_STAMP_EN
        for (int h = 0; h < int'(NUM_HARTS); h++) begin
          if (trap[h] && !trap_seen_q[h]) begin
            stamp_d[h*CNT_W +: CNT_W] = cycle_cnt_q;
          end
        end
`endif
        // Trap takes priority over a coincident timeout.
        if (terminate) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
          state_d     = StDone;
          done_d      = 1'b1;
          timed_out_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    core_reset_d = (state_d != StRun);
    running_d    = (state_d == StRun);
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      rst_cnt_q       <= '0;
      core_reset_q    <= 1'b1;
      running_q       <= 1'b0;
      done_q          <= 1'b0;
      timed_out_q     <= 1'b0;
      trap_seen_q     <= '0;
      first_trap_id_q <= '0;
      cycle_cnt_q     <= '0;
`ifdef RUN_MON_TRAP_STAMP_EN
      stamp_q         <= '0;
`endif
    end else begin
      state_q         <= state_d;
      rst_cnt_q       <= rst_cnt_d;
      core_reset_q    <= core_reset_d;
      running_q       <= running_d;
      done_q          <= done_d;
      timed_out_q     <= timed_out_d;
      trap_seen_q     <= trap_seen_d;
      first_trap_id_q <= first_trap_id_d;
      cycle_cnt_q     <= cycle_cnt_d;
`ifdef RUN_MON_TRAP_STAMP_EN
      stamp_q         <= stamp_d;
`endif
    end
  end

  assign core_reset    = core_reset_q;
  assign running       = running_q;
  assign done          = done_q;
  assign timed_out     = timed_out_q;
  assign trap_seen     = trap_seen_q;
  assign first_trap_id = first_trap_id_q;
  assign cycle_cnt     = cycle_cnt_q;
`ifdef RUN_MON_TRAP_STAMP_EN
  assign trap_stamp    = stamp_q;
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Bench for riscv_run_monitor: three instances (any-trap, wait-all, single hart)
// share start/reset/trap and are checked against a run-level reference model.
module tb_riscv_run_monitor;

  localparam int unsigned MaxC = 50;
  localparam int unsigned CW   = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [3:0] trap4;

  logic [2:0] cr, rn, dn, to;
  logic [3:0] seen_any, seen_all;
  logic [0:0] seen_one;
  logic [1:0] fid_any, fid_all;
  logic [0:0] fid_one;
  logic [CW-1:0] cnt_any, cnt_all, cnt_one;
`ifdef RUN_MON_TRAP_STAMP_EN
  logic [4*CW-1:0] stamp_any, stamp_all;
  logic [CW-1:0]   stamp_one;
`endif

  riscv_run_monitor #(.NUM_HARTS(4), .RESET_CYCLES(2), .MAX_CYCLES(MaxC), .WAIT_ALL(0)) u_any (
    .clk (clk), .reset (reset), .start (start), .trap (trap4),
    .core_reset (cr[0]), .running (rn[0]), .done (dn[0]), .timed_out (to[0]),
    .trap_seen (seen_any), .first_trap_id (fid_any),
`ifdef RUN_MON_TRAP_STAMP_EN
    .trap_stamp (stamp_any),
`endif
    .cycle_cnt (cnt_any)
  );

  riscv_run_monitor #(.NUM_HARTS(4), .RESET_CYCLES(2), .MAX_CYCLES(MaxC), .WAIT_ALL(1)) u_all (
    .clk (clk), .reset (reset), .start (start), .trap (trap4),
    .core_reset (cr[1]), .running (rn[1]), .done (dn[1]), .timed_out (to[1]),
    .trap_seen (seen_all), .first_trap_id (fid_all),
`ifdef RUN_MON_TRAP_STAMP_EN
    .trap_stamp (stamp_all),
`endif
    .cycle_cnt (cnt_all)
  );

  riscv_run_monitor #(.NUM_HARTS(1), .RESET_CYCLES(2), .MAX_CYCLES(MaxC), .WAIT_ALL(0)) u_one (
    .clk (clk), .reset (reset), .start (start), .trap (trap4[0:0]),
    .core_reset (cr[2]), .running (rn[2]), .done (dn[2]), .timed_out (to[2]),
    .trap_seen (seen_one), .first_trap_id (fid_one),
`ifdef RUN_MON_TRAP_STAMP_EN
    .trap_stamp (stamp_one),
`endif
    .cycle_cnt (cnt_one)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] sched [MaxC];
  int         exp_end   [3];
  bit         exp_to    [3];
  logic [3:0] exp_seen  [3];
  int         exp_fid   [3];
  int         exp_stamp [3][4];

  task automatic chk(input string tag, input int d, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, d, o, e);
    end
  endtask

  function automatic logic [31:0] get_seen(input int d);
    case (d)
      0:       return 32'(seen_any);
      1:       return 32'(seen_all);
      default: return 32'(seen_one);
    endcase
  endfunction

  function automatic logic [31:0] get_fid(input int d);
    case (d)
      0:       return 32'(fid_any);
      1:       return 32'(fid_all);
      default: return 32'(fid_one);
    endcase
  endfunction

  function automatic logic [31:0] get_cnt(input int d);
    case (d)
      0:       return 32'(cnt_any);
      1:       return 32'(cnt_all);
      default: return 32'(cnt_one);
    endcase
  endfunction

`ifdef RUN_MON_TRAP_STAMP_EN
  function automatic logic [31:0] get_stamp(input int d, input int h);
    case (d)
      0:       return 32'(stamp_any[h*CW +: CW]);
      1:       return 32'(stamp_all[h*CW +: CW]);
      default: return 32'(stamp_one);
    endcase
  endfunction
`endif

  // Whole-run outcome for one instance, computed from the trap schedule.
  task automatic model(input int d);
    logic [3:0] mask, acc, t;
    bit         wa;
    mask = (d == 2) ? 4'h1 : 4'hf;
    wa   = (d == 1);
    acc  = '0;
    exp_fid[d] = 0;
    exp_to[d]  = 1'b0;
    exp_end[d] = MaxC - 1;
    for (int h = 0; h < 4; h++) exp_stamp[d][h] = 0;
    for (int k = 0; k < MaxC; k++) begin
      t = sched[k] & mask;
      for (int h = 0; h < 4; h++) if (t[h] && !acc[h]) exp_stamp[d][h] = k;
      if (acc == 0 && t != 0) begin
        for (int h = 3; h >= 0; h--) if (t[h]) exp_fid[d] = h;
      end
      acc |= t;
      if (wa ? (acc == mask) : (t != 0)) begin
        exp_end[d] = k;
        break;
      end
      if (k == MaxC - 1) exp_to[d] = 1'b1;
    end
    exp_seen[d] = acc;
  endtask

  task automatic check_idle_like(input int d, input string tag);
    chk({tag, "_core_reset"}, d, 32'(cr[d]), 32'd1);
    chk({tag, "_running"}, d, 32'(rn[d]), 32'd0);
    chk({tag, "_done"}, d, 32'(dn[d]), 32'd0);
    chk({tag, "_timed_out"}, d, 32'(to[d]), 32'd0);
    chk({tag, "_trap_seen"}, d, get_seen(d), 32'd0);
    chk({tag, "_first_trap_id"}, d, get_fid(d), 32'd0);
    chk({tag, "_cycle_cnt"}, d, get_cnt(d), 32'd0);
  endtask

  task automatic check_final(input int d);
    chk("done", d, 32'(dn[d]), 32'd1);
    chk("timed_out", d, 32'(to[d]), 32'(exp_to[d]));
    chk("end_running", d, 32'(rn[d]), 32'd0);
    chk("end_core_reset", d, 32'(cr[d]), 32'd1);
    chk("trap_seen", d, get_seen(d), 32'(exp_seen[d]));
    chk("first_trap_id", d, get_fid(d), 32'(exp_fid[d]));
    chk("cycle_cnt", d, get_cnt(d), 32'(exp_end[d] + 1));
`ifdef RUN_MON_TRAP_STAMP_EN
    for (int h = 0; h < ((d == 2) ? 1 : 4); h++) begin
      chk("trap_stamp", d, get_stamp(d, h), 32'(exp_stamp[d][h]));
    end
`endif
  endtask

  // One run: start pulse, reset hold, RUN driven from sched, optional stray start or reset.
  task automatic do_run(input int reset_at, input bit stray);
    int min_end, stray_at;
    for (int d = 0; d < 3; d++) model(d);
    min_end = exp_end[0];
    for (int d = 1; d < 3; d++) if (exp_end[d] < min_end) min_end = exp_end[d];
    stray_at = stray ? min_end / 2 : -1;
    @(negedge clk);
    start = 1'b1;
    trap4 = '0;
    @(negedge clk);
    start = 1'b0;
    for (int d = 0; d < 3; d++) check_idle_like(d, "hold0");
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk("hold1_core_reset", d, 32'(cr[d]), 32'd1);
    for (int k = 0; k <= int'(MaxC); k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk("running", d, 32'(rn[d]), 32'(k <= exp_end[d]));
        chk("core_reset", d, 32'(cr[d]), 32'(k > exp_end[d]));
        chk("done_timing", d, 32'(dn[d]), 32'(k > exp_end[d]));
      end
      if (k == reset_at) begin
        reset = 1'b1;
        trap4 = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int d = 0; d < 3; d++) check_idle_like(d, "midrun_reset");
        return;
      end
      trap4 = (k < int'(MaxC)) ? sched[k] : 4'h0;
      start = (k == stray_at);
    end
    start = 1'b0;
    for (int d = 0; d < 3; d++) check_final(d);
  endtask

  task automatic clear_sched();
    for (int k = 0; k < int'(MaxC); k++) sched[k] = '0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    trap4 = '0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle_like(d, "reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) check_idle_like(d, "idle");

    // Single hart traps at run cycle 7.
    clear_sched();
    sched[7] = 4'b0001;
    do_run(-1, 1'b0);
    // Two harts at cycle 3, with an ignored start during RUN.
    clear_sched();
    sched[3] = 4'b1010;
    do_run(-1, 1'b1);
    // Staggered traps completing the wait-all set at cycle 9.
    clear_sched();
    sched[2] = 4'b0001;
    sched[5] = 4'b0110;
    sched[9] = 4'b1000;
    do_run(-1, 1'b0);
    // Pure timeout.
    clear_sched();
    do_run(-1, 1'b0);
    // Trap on the last cycle beats the timeout.
    clear_sched();
    sched[49] = 4'b1111;
    do_run(-1, 1'b0);
    // Reset in the middle of RUN.
    clear_sched();
    do_run(20, 1'b0);

    for (int r = 0; r < 20; r++) begin
      int mode;
      mode = $urandom_range(0, 1);
      for (int k = 0; k < int'(MaxC); k++) begin
        if (mode == 0) sched[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
        else sched[k] = ($urandom_range(0, 5) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'h0;
      end
      do_run(-1, ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, required bench to finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/riscv_run_monitor.md
Name: riscv_run_monitor

Overview:
- Synthesisable run-control and end-of-test monitor for one or more RISC-V cores behind `riscv_wrapper`.
- Sequences core reset, counts run cycles, latches per-hart `trap` events and enforces a cycle timeout.
- Reports `done` / `timed_out` status so benches and FPGA top levels terminate on hardware state, not on fixed delays.
- Sits between the top-level clock/reset and the `reset`/`trap` pins of NUM_HARTS wrapper instances.

Parameters:
- NUM_HARTS, 1, number of monitored cores / `trap` inputs (1..32).
- RESET_CYCLES, 2, cycles `core_reset` is held after `start` (>=1).
- MAX_CYCLES, 50, run cycles before timeout (>=2).
- WAIT_ALL, 0: 0 = finish on first trap from any hart; 1 = finish when every hart has trapped.
- CNT_W, $clog2(MAX_CYCLES+1), width of `cycle_cnt` (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- trap  in  NUM_HARTS  per-hart trap flags from the wrapper instances.
- core_reset  out  1  active-high reset driven to the cores.
- running  out  1  high while in RUN.
- done  out  1  sticky; run ended by trap or timeout.
- timed_out  out  1  sticky; run ended by timeout.
- trap_seen  out  NUM_HARTS  sticky OR of `trap` sampled during RUN.
- first_trap_id  out  $clog2(NUM_HARTS)>0 ? $clog2(NUM_HARTS) : 1  lowest hart index trapping in the first trap cycle.
- cycle_cnt  out  CNT_W  RUN cycles elapsed; frozen on termination.

Behaviour:
- FSM states: IDLE, RST_HOLD, RUN, DONE. All outputs are registered.
- On reset:
  - state = IDLE; `core_reset` = 1; `running`, `done`, `timed_out` = 0.
  - `trap_seen`, `first_trap_id`, `cycle_cnt`, internal reset counter = 0.
- IDLE:
  - `core_reset` = 1.
  - `start` -> RST_HOLD; clear `done`, `timed_out`, `trap_seen`, `first_trap_id`, `cycle_cnt`.
- RST_HOLD:
  - `core_reset` = 1 for exactly RESET_CYCLES cycles.
  - Then -> RUN; `core_reset` = 0 and `running` = 1 from the first RUN cycle.
- RUN:
  - `cycle_cnt` increments by 1 every cycle.
  - `trap_seen` <= `trap_seen` | `trap`. `trap` is ignored outside RUN.
  - In the first cycle with any `trap` bit set, latch the lowest set index into `first_trap_id`.
  - Terminate condition: WAIT_ALL=0 -> |`trap`; WAIT_ALL=1 -> (`trap_seen` | `trap`) all ones.
  - On terminate -> DONE: `done` = 1 next cycle, `running` = 0, `core_reset` = 1.
  - If `cycle_cnt` == MAX_CYCLES-1 and no terminate -> DONE with `timed_out` = 1.
  - Simultaneous terminate and timeout: trap wins, `timed_out` = 0.
- DONE:
  - All status outputs held; `core_reset` = 1.
  - `start` restarts as from IDLE, with the same clears.
- `start` is ignored in RST_HOLD and RUN.
- `reset` in any state, including mid-RUN, returns to the reset values on the next edge.
- Latency: `done` rises 1 cycle after the terminating `trap` sample.

Optional Feature:
- Macro: RUN_MON_TRAP_STAMP_EN.
- Defined:
  - Adds output `trap_stamp` [NUM_HARTS*CNT_W] holding each hart's `cycle_cnt` value at its first trap.
  - Stamps are cleared on reset/`start`; a stamp stays 0 if that hart never traps.
- Undefined: no `trap_stamp` port and no stamp registers.

Decomposition:
- Package `riscv_run_pkg`:
  - state enum `run_state_e` {IDLE, RST_HOLD, RUN, DONE};
  - function `lowest_set_idx`;
  - default constants for RESET_CYCLES and MAX_CYCLES.
- One sub-module: `run_prio_enc`, a parametrised lowest-index priority encoder with a valid output, used for `first_trap_id`.

Test Plan:
- Reset, then `start` with NUM_HARTS=1, RESET_CYCLES=2; `trap` at RUN cycle 7 -> `core_reset` high exactly 2 cycles after `start`, `done`=1 one cycle later, `cycle_cnt`=8, `timed_out`=0, `trap_seen`=1.
- NUM_HARTS=4, WAIT_ALL=0; `trap`=4'b1010 at cycle 3 -> `first_trap_id`=1, `trap_seen`=4'b1010, `done`=1.
- NUM_HARTS=4, WAIT_ALL=1; traps 4'b0001 @2, 4'b0110 @5, 4'b1000 @9 -> `done` only after cycle 9, `first_trap_id`=0, `trap_seen`=4'b1111.
- MAX_CYCLES=50, no trap -> `done`=1, `timed_out`=1, `cycle_cnt`=50; `trap` at cycle 49 instead -> `timed_out`=0.
- Assert `reset` mid-RUN at cycle 20 -> next edge: IDLE, `core_reset`=1, all status 0; extra `start` during RUN is ignored; `start` in DONE re-runs with cleared status.
- With RUN_MON_TRAP_STAMP_EN, NUM_HARTS=2, traps on hart1 @4 and hart0 @11 (WAIT_ALL=1) -> `trap_stamp` = {4, 11}.
